// File: rtl/rx_pkg.sv
// Shared definitions for the serial receive path.
// Holds the receiver FSM state type and the line-level constants used to
// recognise an idle line and a start bit.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundle of the serial receive signals.
// Ports (slave = receiver side):
//   bit_en     sample strobe into the receiver
//   serial_in  1-bit serial line, idles high
//   data_out   last correctly framed word
//   data_valid one-cycle pulse on a data_out update
//   frame_err  one-cycle pulse on a low stop bit
//   busy       high while a frame is in progress
interface serial_deserializer_if #(
  parameter int WIDTH = 4
) ();

  logic             bit_en;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output bit_en, serial_in,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  bit_en, serial_in,
    output data_out, data_valid, frame_err, busy
  );

endinterface

// File: rtl/shift_in_reg.sv
// Serial-in, parallel-out shift register.
// Ports:
//   clk       system clock
//   reset     synchronous active-high clear
//   shift_en  shift bit_in in on this edge
//   bit_in    incoming serial bit
//   q         parallel contents
// With MSB_FIRST=0 bits enter at the top and move down, so after WIDTH
// shifts the first bit sits in q[0]. With MSB_FIRST=1 bits enter at the
// bottom and move up, so the first bit ends in q[WIDTH-1].
module shift_in_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  generate
    if (WIDTH == 1) begin : g_single
      assign q_next = bit_in;
    end else if (MSB_FIRST) begin : g_msb_first
      assign q_next = {q_reg[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign q_next = {bit_in, q_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (shift_en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial receiver: start bit, WIDTH data bits, stop bit.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, aborts any frame silently
//   bus    serial_deserializer_if.slave (bit_en, serial_in in;
//          data_out, data_valid, frame_err, busy out)
// The line is only examined on edges with bit_en=1; bit timing comes from
// outside. data_valid is meant to drive a downstream register enable, so it
// is a single-cycle pulse regardless of strobe spacing.
module serial_deserializer
  import rx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_deserializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             data_valid_reg, data_valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             shift_en;
  logic [WIDTH-1:0] word;

  shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .bit_in   (bus.serial_in),
    .q        (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Pulses default low, so they last exactly one cycle even when the
  // strobe is asserted on consecutive edges.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    shift_en        = 1'b0;

    if (bus.bit_en) begin
      case (state_reg)
        IDLE: begin
          if (bus.serial_in == START_BIT) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            state_next = STOP;
          end
        end
        STOP: begin
          if (bus.serial_in == LINE_IDLE) begin
            data_out_next   = word;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line is not
          // mistaken for a new start bit.
          if (bus.serial_in == LINE_IDLE) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule
